dct_row: RTL and testbench



---
 rtl/dct_row_if.sv | 22 ++
 rtl/dct_row.sv | 168 ++++++++++++++++
 tb/tb_dct_row.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dct_row_if.sv
// Streaming port bundle for the forward row DCT: serial samples in, serial coefficients out.
interface dct_row_if #(
  parameter int unsigned DW = 16
) ();
  logic signed [DW-1:0] x;
  logic                 x_valid;
  logic [1:0]           mode;
  logic signed [DW-1:0] y;
  logic                 y_valid;
  logic                 y_last;
  logic                 busy;

  modport master (
    output x, x_valid, mode,
    input  y, y_valid, y_last, busy
  );

  modport slave (
    input  x, x_valid, mode,
    output y, y_valid, y_last, busy
  );
endinterface

// File: rtl/dct_row.sv
// Forward 1-D row DCT (HEVC integer basis, 4- or 8-point). Samples arrive serially, the
// whole row is transformed in the cycle of its last sample, coefficients stream out serially.
module dct_row #(
  parameter int unsigned SHIFT = 7,
  parameter int unsigned DW    = 16
) (
  input logic    clk,
  input logic    rst_n,
  dct_row_if.slave bus
);

  localparam int unsigned AW = 26;
  typedef logic signed [AW-1:0] acc_t;

  localparam acc_t Round = acc_t'(1) <<< (SHIFT - 1);
  localparam acc_t MaxV  = (acc_t'(1) <<< (DW - 1)) - acc_t'(1);
  localparam acc_t MinV  = -(acc_t'(1) <<< (DW - 1));

  typedef enum logic [0:0] {StIdle, StOut} state_e;

  // 8-point basis; the 4-point basis is rows 0,2,4,6 restricted to columns 0..3.
  function automatic logic signed [7:0] coef8(input logic [2:0] k, input logic [2:0] n);
    logic [63:0] row;
    row = '0;
    unique case (k)
      3'd0: row = {8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64};
      3'd1: row = {8'sd89, 8'sd75, 8'sd50, 8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89};
      3'd2: row = {8'sd83, 8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36, 8'sd36, 8'sd83};
      3'd3: row = {8'sd75, -8'sd18, -8'sd89, -8'sd50, 8'sd50, 8'sd89, 8'sd18, -8'sd75};
      3'd4: row = {8'sd64, -8'sd64, -8'sd64, 8'sd64, 8'sd64, -8'sd64, -8'sd64, 8'sd64};
      3'd5: row = {8'sd50, -8'sd89, 8'sd18, 8'sd75, -8'sd75, -8'sd18, 8'sd89, -8'sd50};
      3'd6: row = {8'sd36, -8'sd83, 8'sd83, -8'sd36, -8'sd36, 8'sd83, -8'sd83, 8'sd36};
      3'd7: row = {8'sd18, -8'sd50, 8'sd75, -8'sd89, 8'sd89, -8'sd75, 8'sd50, -8'sd18};
    endcase
    return row[8*(7-n) +: 8];
  endfunction

  // Round-half-up then floor shift, clamped to the output range.
  function automatic logic signed [DW-1:0] round_sat(input acc_t a);
    acc_t r;
    r = (a + Round) >>> SHIFT;
    if (r > MaxV) return MaxV[DW-1:0];
    if (r < MinV) return MinV[DW-1:0];
    return r[DW-1:0];
  endfunction

  logic [2:0]           cnt_q;
  logic                 mode8_q;
  logic signed [DW-1:0] sr_q   [7];
  logic signed [DW-1:0] bank_q [8];
  logic signed [DW-1:0] coef_d [8];
  logic signed [DW-1:0] xs     [8];
  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic                 out8_q, out8_d;
  logic signed [DW-1:0] y_q;
  logic                 y_valid_q, y_last_q;

  logic       accept, row8, done;
  logic [2:0] last_idx;
  acc_t       acc;
  logic signed [7:0] ck;

  // Reserved modes only block the start of a row; mid-row the latched mode rules.
  assign accept   = bus.x_valid && ((cnt_q != 3'd0) || !bus.mode[1]);
  assign row8     = (cnt_q == 3'd0) ? bus.mode[0] : mode8_q;
  assign last_idx = row8 ? 3'd7 : 3'd3;
  assign done     = accept && (cnt_q == last_idx);

  // Full-row matrix multiply from the delay line plus the sample arriving this cycle.
  always_comb begin
    for (int n = 0; n < 8; n++) xs[n] = '0;
    acc = '0;
    ck  = '0;
    if (row8) begin
      for (int n = 0; n < 7; n++) xs[n] = sr_q[6-n];
      xs[7] = bus.x;
    end else begin
      for (int n = 0; n < 3; n++) xs[n] = sr_q[2-n];
      xs[3] = bus.x;
    end
    for (int k = 0; k < 8; k++) begin
      acc = '0;
      for (int n = 0; n < 8; n++) begin
        if (row8)       ck = coef8(3'(k), 3'(n));
        else if (k < 4) ck = coef8(3'(2 * k), 3'(n));
        else            ck = '0;
        acc = acc + acc_t'(ck) * acc_t'(xs[n]);
      end
      coef_d[k] = round_sat(acc);
    end
  end

  // Sample collection, row-mode latch and coefficient bank load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mode8_q <= 1'b0;
      for (int i = 0; i < 7; i++) sr_q[i] <= '0;
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
    end else if (accept) begin
      sr_q[0] <= bus.x;
      for (int i = 1; i < 7; i++) sr_q[i] <= sr_q[i-1];
      if (cnt_q == 3'd0) mode8_q <= bus.mode[0];
      cnt_q <= done ? 3'd0 : cnt_q + 3'd1;
      if (done) begin
        for (int i = 0; i < 8; i++) bank_q[i] <= coef_d[i];
      end
    end
  end

  // Output sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      out8_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out8_q  <= out8_d;
    end
  end

  // A completion always restarts the sequence; for same-size back-to-back rows it can only
  // land on the final index of the previous row, which still reads the old bank.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out8_d  = out8_q;
    if (done) begin
      state_d = StOut;
      idx_d   = 3'd0;
      out8_d  = row8;
    end else begin
      unique case (state_q)
        StIdle: ;
        StOut: begin
          if (idx_q == (out8_q ? 3'd7 : 3'd3)) begin
            state_d = StIdle;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      endcase
    end
  end

  // Registered coefficient stream; y is forced to zero whenever it is not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      y_q       <= (state_q == StOut) ? bank_q[idx_q] : '0;
      y_valid_q <= (state_q == StOut);
      y_last_q  <= (state_q == StOut) && (idx_q == (out8_q ? 3'd7 : 3'd3));
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_last  = y_last_q;
  assign bus.busy    = (cnt_q != 3'd0);

endmodule

// File: tb/tb_dct_row.sv
// Directed bench for dct_row: table of rows with hand-computed coefficients, plus hand
// sequences for gaps, mode changes, reserved mode and reset.
module tb_dct_row;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  dct_row_if #(.DW(16)) bus ();

  dct_row #(.SHIFT(7), .DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    bit              is8;
    int              gap;
    logic [7:0][15:0] xv;
    logic [7:0][15:0] ev;
  } vec_t;

  typedef struct {
    logic [15:0] v;
    bit          last;
    int          cyc;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];
  exp_t e_mon;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic add_vec(input bit is8, input int gap,
                         input int x0, input int x1, input int x2, input int x3,
                         input int x4, input int x5, input int x6, input int x7,
                         input int e0, input int e1, input int e2, input int e3,
                         input int e4, input int e5, input int e6, input int e7);
    vec_t v;
    v.is8 = is8;
    v.gap = gap;
    v.xv[0] = 16'(x0); v.xv[1] = 16'(x1); v.xv[2] = 16'(x2); v.xv[3] = 16'(x3);
    v.xv[4] = 16'(x4); v.xv[5] = 16'(x5); v.xv[6] = 16'(x6); v.xv[7] = 16'(x7);
    v.ev[0] = 16'(e0); v.ev[1] = 16'(e1); v.ev[2] = 16'(e2); v.ev[3] = 16'(e3);
    v.ev[4] = 16'(e4); v.ev[5] = 16'(e5); v.ev[6] = 16'(e6); v.ev[7] = 16'(e7);
    tbl.push_back(v);
  endtask

  // Called at the negedge where the last sample is driven: Y[k] is visible from cyc+2+k.
  task automatic push_exp(input logic [7:0][15:0] ev, input int nn);
    exp_t e;
    for (int k = 0; k < nn; k++) begin
      e.v    = ev[k];
      e.last = (k == nn - 1);
      e.cyc  = cyc + 2 + k;
      q.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.x_valid = 1'b0;
    end
  endtask

  task automatic drive_row(input vec_t v);
    int nn;
    nn = v.is8 ? 8 : 4;
    idle_cycles(v.gap);
    for (int i = 0; i < nn; i++) begin
      @(negedge clk);
      bus.mode    = v.is8 ? 2'b01 : 2'b00;
      bus.x       = v.xv[i];
      bus.x_valid = 1'b1;
      if (i == nn - 1) push_exp(v.ev, nn);
    end
  endtask

  // Output monitor: every valid beat must match the next expected coefficient and cycle.
  always @(negedge clk) begin
    if (bus.y_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_y: got y=%0d with no coefficient pending", $signed(bus.y));
      end else begin
        e_mon = q.pop_front();
        if (bus.y !== e_mon.v || bus.y_last !== e_mon.last || cyc != e_mon.cyc) begin
          n_fail++;
          $display("FAIL y_beat: got y=%0d last=%0b cyc=%0d want y=%0d last=%0b cyc=%0d",
                   $signed(bus.y), bus.y_last, cyc, $signed(e_mon.v), e_mon.last, e_mon.cyc);
        end
      end
    end else begin
      n_cmp++;
      if (bus.y !== 16'd0 || bus.y_last !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_y: got y=%0d last=%0b want 0/0", $signed(bus.y), bus.y_last);
      end
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        n_fail++;
        $display("FAIL missing_y: got no y_valid at cyc %0d want y=%0d",
                 cyc, $signed(q[0].v));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t hv;
    bus.x = '0;
    bus.x_valid = 1'b0;
    bus.mode = 2'b01;

    // Reset state
    #12;
    check("rst_y", int'($signed(bus.y)), 0);
    check("rst_y_valid", int'(bus.y_valid), 0);
    check("rst_y_last", int'(bus.y_last), 0);
    check("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // is8 gap | x0..x7 | expected Y0..Y7
    add_vec(1, 2, 128, 128, 128, 128, 128, 128, 128, 128, 512, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 128, 0, 0, 0, 0, 0, 0, 0, 64, 89, 83, 75, 64, 50, 36, 18);
    add_vec(1, 0, -128, 0, 0, 0, 0, 0, 0, 0, -64, -89, -83, -75, -64, -50, -36, -18);
    add_vec(1, 0, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
            32767, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
            -32768, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 8, 100, 100, 100, 100, 0, 0, 0, 0, 200, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 128, 0, 0, 0, 0, 0, 0, 0, 64, 83, 64, 36, 0, 0, 0, 0);
    add_vec(0, 0, 10, 20, 30, 40, 0, 0, 0, 0, 50, -22, 0, -2, 0, 0, 0, 0);
    add_vec(1, 0, 128, 128, 128, 128, 128, 128, 128, 128, 512, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) drive_row(tbl[i]);
    idle_cycles(12);

    // Gap of 3 cycles after sample 3, mode flipped to 4-point mid-row: still 8 outputs.
    hv = tbl[0];
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          bus.x_valid = 1'b0;
          bus.mode = 2'b00;
          check("gap_busy", int'(bus.busy), 1);
        end
      end
      @(negedge clk);
      bus.mode = (i < 4) ? 2'b01 : 2'b00;
      bus.x = hv.xv[i];
      bus.x_valid = 1'b1;
      if (i == 7) push_exp(hv.ev, 8);
    end
    idle_cycles(12);

    // Reserved mode while idle: nothing accepted, nothing output.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) check("rsvd_busy", int'(bus.busy), 0);
      bus.mode = 2'b10;
      bus.x = 16'sd500;
      bus.x_valid = 1'b1;
    end
    idle_cycles(4);
    check("rsvd_busy_end", int'(bus.busy), 0);

    // Reset after 5 samples of an 8-point row, then a fresh 4-point row.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.mode = 2'b01;
      bus.x = 16'sd1000;
      bus.x_valid = 1'b1;
    end
    @(negedge clk);
    bus.x_valid = 1'b0;
    check("midrow_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrow_rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_row(tbl[5]);
    idle_cycles(8);

    // Reset while coefficients are streaming clears y immediately.
    drive_row(tbl[1]);
    idle_cycles(3);
    @(posedge clk);
    #2;
    check("preout_valid", int'(bus.y_valid), 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("outrst_y", int'($signed(bus.y)), 0);
    check("outrst_valid", int'(bus.y_valid), 0);
    check("outrst_last", int'(bus.y_last), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(10);

    // Drain with a bound; anything still pending never appeared.
    for (int i = 0; i < 40 && q.size() > 0; i++) idle_cycles(1);
    check("drain_pending", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
